// File: rtl/flp_align_sched.sv
// Round-robin scheduler feeding one shared FP exponent aligner (flp_align) from two requesters.
// Optional accepted-request counters are enabled with FLP_ALIGN_SCHED_STATS_EN.

module flp_align #(
   parameter int EWIDTH  = 8,
   parameter int SWIDTH  = 23,
   parameter int RSWIDTH = 2
) (
   input  logic [SWIDTH:0]         sg1,
   input  logic [SWIDTH:0]         sg2,
   input  logic [EWIDTH-1:0]       ex1,
   input  logic [EWIDTH-1:0]       ex2,
   output logic [SWIDTH+RSWIDTH:0] al1,
   output logic [SWIDTH+RSWIDTH:0] al2,
   output logic [EWIDTH-1:0]       ex
);
   logic [SWIDTH+RSWIDTH:0] ext1, ext2;
   logic [EWIDTH-1:0]       diff;

   assign ext1 = {sg1, {RSWIDTH{1'b0}}};
   assign ext2 = {sg2, {RSWIDTH{1'b0}}};

   // The smaller operand shifts right; shift amounts past the width flush it to zero.
   always_comb begin
      diff = '0;
      al1  = ext1;
      al2  = ext2;
      ex   = ex1;
      if (ex1 >= ex2) begin
         diff = ex1 - ex2;
         al2  = ext2 >> diff;
      end else begin
         diff = ex2 - ex1;
         al1  = ext1 >> diff;
         ex   = ex2;
      end
   end
endmodule

module flp_align_sched #(
   parameter int EWIDTH  = 8,
   parameter int SWIDTH  = 23,
   parameter int RSWIDTH = 2,
   parameter int CWIDTH  = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [SWIDTH:0]         i_sg1_0,
   input  logic [SWIDTH:0]         i_sg2_0,
   input  logic [EWIDTH-1:0]       i_ex1_0,
   input  logic [EWIDTH-1:0]       i_ex2_0,
   input  logic                    i_valid_0,
   output logic                    o_ready_0,
   input  logic [SWIDTH:0]         i_sg1_1,
   input  logic [SWIDTH:0]         i_sg2_1,
   input  logic [EWIDTH-1:0]       i_ex1_1,
   input  logic [EWIDTH-1:0]       i_ex2_1,
   input  logic                    i_valid_1,
   output logic                    o_ready_1,
   output logic [SWIDTH+RSWIDTH:0] o_sg1,
   output logic [SWIDTH+RSWIDTH:0] o_sg2,
   output logic [EWIDTH-1:0]       o_ex,
   output logic                    o_tag,
   output logic                    o_valid,
   input  logic                    i_ready
`ifdef FLP_ALIGN_SCHED_STATS_EN
   ,
   output logic [CWIDTH-1:0]       o_cnt0,
   output logic [CWIDTH-1:0]       o_cnt1
`endif
);
   typedef struct packed {
      logic [SWIDTH:0]   sg1;
      logic [SWIDTH:0]   sg2;
      logic [EWIDTH-1:0] ex1;
      logic [EWIDTH-1:0] ex2;
   } op_t;

   op_t                     s1_op;
   logic                    s1_tag, s1_v;
   logic [SWIDTH+RSWIDTH:0] s2_sg1, s2_sg2;
   logic [EWIDTH-1:0]       s2_ex;
   logic                    s2_tag, s2_v;
   logic                    last;

   logic                    s1_adv, s2_adv, grant, acc0, acc1;
   logic [SWIDTH+RSWIDTH:0] al1, al2;
   logic [EWIDTH-1:0]       al_ex;

   assign s2_adv = !s2_v || i_ready;
   assign s1_adv = !s1_v || s2_adv;

   // Tie goes to the requester not granted last; otherwise the sole valid one.
   always_comb begin
      grant = 1'b0;
      if (i_valid_0 && i_valid_1) grant = !last;
      else if (i_valid_1)         grant = 1'b1;
   end

   assign o_ready_0 = !rst && s1_adv && !grant;
   assign o_ready_1 = !rst && s1_adv &&  grant;
   assign acc0      = i_valid_0 && o_ready_0;
   assign acc1      = i_valid_1 && o_ready_1;

   flp_align #(.EWIDTH(EWIDTH), .SWIDTH(SWIDTH), .RSWIDTH(RSWIDTH)) u_align (
      .sg1 (s1_op.sg1),
      .sg2 (s1_op.sg2),
      .ex1 (s1_op.ex1),
      .ex2 (s1_op.ex2),
      .al1 (al1),
      .al2 (al2),
      .ex  (al_ex)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_op  <= '0;
         s1_tag <= 1'b0;
         s1_v   <= 1'b0;
         s2_sg1 <= '0;
         s2_sg2 <= '0;
         s2_ex  <= '0;
         s2_tag <= 1'b0;
         s2_v   <= 1'b0;
         last   <= 1'b1;
      end else begin
         if (s2_adv) begin
            s2_sg1 <= al1;
            s2_sg2 <= al2;
            s2_ex  <= al_ex;
            s2_tag <= s1_tag;
            s2_v   <= s1_v;
         end
         if (acc0) begin
            s1_op  <= '{sg1: i_sg1_0, sg2: i_sg2_0, ex1: i_ex1_0, ex2: i_ex2_0};
            s1_tag <= 1'b0;
            s1_v   <= 1'b1;
            last   <= 1'b0;
         end else if (acc1) begin
            s1_op  <= '{sg1: i_sg1_1, sg2: i_sg2_1, ex1: i_ex1_1, ex2: i_ex2_1};
            s1_tag <= 1'b1;
            s1_v   <= 1'b1;
            last   <= 1'b1;
         end else if (s1_adv) begin
            s1_v   <= 1'b0;
         end
      end
   end

   assign o_sg1   = s2_sg1;
   assign o_sg2   = s2_sg2;
   assign o_ex    = s2_ex;
   assign o_tag   = s2_tag;
   assign o_valid = s2_v;

`ifdef FLP_ALIGN_SCHED_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         o_cnt0 <= '0;
         o_cnt1 <= '0;
      end else begin
         if (acc0) o_cnt0 <= o_cnt0 + 1'b1;
         if (acc1) o_cnt1 <= o_cnt1 + 1'b1;
      end
   end
`endif
endmodule

// File: tb/tb_flp_align_sched.sv
// Scoreboard bench for flp_align_sched: expectations queued on accept, checked on output handshake.
// Counter checks run when FLP_ALIGN_SCHED_STATS_EN is defined.

module tb_flp_align_sched;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_valid_0 = 1'b0, i_valid_1 = 1'b0, i_ready = 1'b1;
   logic        o_ready_0, o_ready_1, o_tag, o_valid;
   logic [23:0] i_sg1_0, i_sg2_0, i_sg1_1, i_sg2_1;
   logic [7:0]  i_ex1_0, i_ex2_0, i_ex1_1, i_ex2_1;
   logic [25:0] o_sg1, o_sg2;
   logic [7:0]  o_ex;
`ifdef FLP_ALIGN_SCHED_STATS_EN
   logic [15:0] o_cnt0, o_cnt1;
`endif

   always #5 clk = ~clk;

   // Directed vectors: A=spec example, B=ex2 larger by 1, C=equal exps, D=zero, E=huge diff, F=diff 25
   logic [23:0] v_sg1 [6] = '{24'h001000, 24'h800000, 24'h123456, 24'h000000, 24'hFFFFFF, 24'hFFFFFF};
   logic [7:0]  v_ex1 [6] = '{8'h85,      8'h7F,      8'h10,      8'h00,      8'h01,      8'h20};
   logic [23:0] v_sg2 [6] = '{24'h001000, 24'hC00000, 24'h654321, 24'h000000, 24'h800000, 24'hFFFFFF};
   logic [7:0]  v_ex2 [6] = '{8'h82,      8'h80,      8'h10,      8'h00,      8'hFF,      8'h07};
   logic [25:0] r_sg1 [6] = '{26'h0004000, 26'h1000000, 26'h048D158, 26'h0, 26'h0000000, 26'h3FFFFFC};
   logic [25:0] r_sg2 [6] = '{26'h0000800, 26'h3000000, 26'h1950C84, 26'h0, 26'h2000000, 26'h0000001};
   logic [7:0]  r_ex  [6] = '{8'h85,      8'h80,      8'h10,      8'h00,      8'hFF,      8'h20};

   int vsel0 = 0, vsel1 = 0;
   assign i_sg1_0 = v_sg1[vsel0];  assign i_sg2_0 = v_sg2[vsel0];
   assign i_ex1_0 = v_ex1[vsel0];  assign i_ex2_0 = v_ex2[vsel0];
   assign i_sg1_1 = v_sg1[vsel1];  assign i_sg2_1 = v_sg2[vsel1];
   assign i_ex1_1 = v_ex1[vsel1];  assign i_ex2_1 = v_ex2[vsel1];

   flp_align_sched dut (
      .clk(clk), .rst(rst),
      .i_sg1_0(i_sg1_0), .i_sg2_0(i_sg2_0), .i_ex1_0(i_ex1_0), .i_ex2_0(i_ex2_0),
      .i_valid_0(i_valid_0), .o_ready_0(o_ready_0),
      .i_sg1_1(i_sg1_1), .i_sg2_1(i_sg2_1), .i_ex1_1(i_ex1_1), .i_ex2_1(i_ex2_1),
      .i_valid_1(i_valid_1), .o_ready_1(o_ready_1),
      .o_sg1(o_sg1), .o_sg2(o_sg2), .o_ex(o_ex), .o_tag(o_tag), .o_valid(o_valid),
      .i_ready(i_ready)
`ifdef FLP_ALIGN_SCHED_STATS_EN
      , .o_cnt0(o_cnt0), .o_cnt1(o_cnt1)
`endif
   );

   typedef struct {
      logic [25:0] sg1;
      logic [25:0] sg2;
      logic [7:0]  ex;
      logic        tag;
   } exp_t;

   exp_t sb [$];
   int   acc_tags [$];
   int   errors = 0, checks = 0, acc_cnt = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input int v, input logic tag);
      exp_t e;
      e.sg1 = r_sg1[v]; e.sg2 = r_sg2[v]; e.ex = r_ex[v]; e.tag = tag;
      return e;
   endfunction

   // Monitor: pop/compare on output handshake, then queue expectation for any accept.
   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
      end else begin
         if (o_valid && i_ready) begin
            if (sb.size() == 0) begin
               chk("sb_unexpected_output", 64'(o_valid), 64'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("sb_tag", 64'(o_tag), 64'(e.tag));
               chk("sb_ex",  64'(o_ex),  64'(e.ex));
               chk("sb_sg1", 64'(o_sg1), 64'(e.sg1));
               chk("sb_sg2", 64'(o_sg2), 64'(e.sg2));
            end
         end
         if (i_valid_0 && o_ready_0) begin
            sb.push_back(mk(vsel0, 1'b0)); acc_tags.push_back(0); acc_cnt++;
         end
         if (i_valid_1 && o_ready_1) begin
            sb.push_back(mk(vsel1, 1'b1)); acc_tags.push_back(1); acc_cnt++;
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic drain(input string name);
      int k = 0;
      while (sb.size() != 0 && k < 30) begin step(1); k++; end
      chk(name, 64'(sb.size()), 64'd0);
   endtask

   initial begin
      int base, a0;
      step(3);
      chk("rst_o_valid", 64'(o_valid), 64'd0);
      chk("rst_o_ex",    64'(o_ex),    64'd0);
      chk("rst_o_sg1",   64'(o_sg1),   64'd0);
      chk("rst_o_tag",   64'(o_tag),   64'd0);
      i_valid_0 = 1'b1; i_valid_1 = 1'b1;
      #1;
      chk("rst_ready0", 64'(o_ready_0), 64'd0);
      chk("rst_ready1", 64'(o_ready_1), 64'd0);
      i_valid_0 = 1'b0; i_valid_1 = 1'b0;
`ifdef FLP_ALIGN_SCHED_STATS_EN
      chk("rst_cnt0", 64'(o_cnt0), 64'd0);
`endif
      rst = 1'b0;
      step(1);

      // Single request, latency two edges
      vsel0 = 0; i_valid_0 = 1'b1;
      step(1);
      i_valid_0 = 1'b0;
      chk("lat_not_yet", 64'(o_valid), 64'd0);
      step(1);
      chk("lat_valid", 64'(o_valid), 64'd1);
      drain("drain_single");
      step(2);

      // Zero operands from requester 1
      vsel1 = 3; i_valid_1 = 1'b1;
      step(1);
      i_valid_1 = 1'b0;
      drain("drain_zero");

      // Contention: grants alternate starting with requester 0
      base = acc_tags.size();
      vsel0 = 1; vsel1 = 2; i_valid_0 = 1'b1; i_valid_1 = 1'b1;
      step(6);
      i_valid_0 = 1'b0; i_valid_1 = 1'b0;
      chk("cont_accepts", 64'(acc_tags.size() - base), 64'd6);
      for (int i = 0; i < 6 && base + i < acc_tags.size(); i++)
         chk("cont_tag_seq", 64'(acc_tags[base+i]), 64'(i % 2));
      drain("drain_cont");

      // Backpressure: exactly two accepts fill S1/S2, outputs hold
      a0 = acc_cnt;
      vsel0 = 4; vsel1 = 5; i_ready = 1'b0; i_valid_0 = 1'b1; i_valid_1 = 1'b1;
      step(3);
      for (int i = 0; i < 3; i++) begin
         chk("bp_ready0", 64'(o_ready_0), 64'd0);
         chk("bp_ready1", 64'(o_ready_1), 64'd0);
         chk("bp_valid",  64'(o_valid),   64'd1);
         chk("bp_ex",     64'(o_ex),      64'hFF);
         chk("bp_tag",    64'(o_tag),     64'd0);
         chk("bp_sg2",    64'(o_sg2),     64'h2000000);
         step(1);
      end
      chk("bp_accepts", 64'(acc_cnt - a0), 64'd2);
      i_valid_0 = 1'b0; i_valid_1 = 1'b0; i_ready = 1'b1;
      drain("drain_bp");
      step(1);
      chk("bp_idle_after", 64'(o_valid), 64'd0);

      // Reset mid-flight
      i_ready = 1'b0; vsel0 = 1; vsel1 = 2; i_valid_0 = 1'b1; i_valid_1 = 1'b1;
      step(4);
      rst = 1'b1;
      step(1);
      chk("mrst_valid",  64'(o_valid),   64'd0);
      chk("mrst_ex",     64'(o_ex),      64'd0);
      chk("mrst_ready0", 64'(o_ready_0), 64'd0);
      chk("mrst_ready1", 64'(o_ready_1), 64'd0);
      rst = 1'b0; i_ready = 1'b1;
      #1;
      chk("mrst_tie_r0", 64'(o_ready_0), 64'd1);
      chk("mrst_tie_r1", 64'(o_ready_1), 64'd0);
      step(3);
      i_valid_0 = 1'b0; i_valid_1 = 1'b0;
      drain("drain_mrst");

`ifdef FLP_ALIGN_SCHED_STATS_EN
      rst = 1'b1; step(2); rst = 1'b0;
      chk("st_rst_cnt1", 64'(o_cnt1), 64'd0);
      vsel0 = 0; i_valid_0 = 1'b1;
      step(70000);
      i_valid_0 = 1'b0;
      chk("st_cnt0", 64'(o_cnt0), 64'd4464);
      chk("st_cnt1", 64'(o_cnt1), 64'd0);
      drain("drain_stats");
`endif

      step(2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
